// File: rtl/calc_alu_sequencer.sv
// Multi-cycle calculator ALU: add/sub in one pass, shift-add multiply over WIDTH passes
// through a single ripple-carry adder. Define CALC_ALU_OVF_FLAG_EN to add the ovf output.

module calc_alu_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module calc_alu_sequencer #(
  parameter int WIDTH = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH:0]     a,
  input  logic [WIDTH:0]     b,
  input  logic               clear,
  output logic               ready,
  output logic               busy,
  output logic               done,
`ifdef CALC_ALU_OVF_FLAG_EN
  output logic               ovf,
`endif
  output logic [2*WIDTH-1:0] result
);
  localparam int RW = 2*WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);
  localparam logic [1:0] OP_ADDU = 2'b00, OP_MUL = 2'b01, OP_SUBS = 2'b10, OP_ADDS = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t          state, state_nx;
  logic [1:0]      op_r;
  logic [WIDTH:0]  a_r, b_r, b_inv;
  logic [RW-1:0]   acc, mcand;
  logic [WIDTH-1:0] mlier;
  logic [CW-1:0]   cnt;
  logic [RW-1:0]   add_x, add_y, sum;
  logic [RW-1:0]   c;
  logic            add_ci, fin;

  // Operands are zero-extended into the shared adder so the carry-out lands in sum[]
  assign b_inv = ~b_r;
  always_comb begin
    add_x  = '0;
    add_y  = '0;
    add_ci = 1'b0;
    case (op_r)
      OP_ADDU: begin add_x = RW'(a_r[WIDTH-1:0]); add_y = RW'(b_r[WIDTH-1:0]); end
      OP_ADDS: begin add_x = RW'(a_r); add_y = RW'(b_r); end
      OP_SUBS: begin add_x = RW'(a_r); add_y = RW'(b_inv); add_ci = 1'b1; end
      default: begin add_x = acc; add_y = mlier[0] ? mcand : '0; end
    endcase
  end

  assign c[0] = add_ci;
  for (genvar i = 0; i < RW; i++) begin : g_rca
    if (i < RW-1) begin : g_fa
      calc_alu_fa u_fa (.x(add_x[i]), .y(add_y[i]), .ci(c[i]), .s(sum[i]), .co(c[i+1]));
    end else begin : g_msb
      assign sum[i] = add_x[i] ^ add_y[i] ^ c[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    if (clear) state_nx = S_IDLE;
    else begin
      case (state)
        S_IDLE:  if (start) state_nx = S_EXEC;
        S_EXEC:  if (op_r != OP_MUL || cnt == LAST) state_nx = S_DONE;
        S_DONE:  state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      S_IDLE:  ready = 1'b1;
      S_EXEC:  busy  = 1'b1;
      S_DONE:  begin busy = 1'b1; done = 1'b1; end
      default: ready = 1'b0;
    endcase
  end

  assign fin = (state == S_EXEC) && (state_nx == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r   <= '0;
      a_r    <= '0;
      b_r    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mlier  <= '0;
      cnt    <= '0;
      result <= '0;
    end else if (clear) begin
      cnt    <= '0;
      result <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        op_r  <= op;
        a_r   <= a;
        b_r   <= b;
        acc   <= '0;
        mcand <= RW'(a[WIDTH-1:0]);
        mlier <= b[WIDTH-1:0];
        cnt   <= '0;
      end else if (state == S_EXEC && op_r == OP_MUL) begin
        acc   <= sum;
        mcand <= mcand << 1;
        mlier <= mlier >> 1;
        cnt   <= (cnt == LAST) ? '0 : cnt + CW'(1);
      end
      // Accumulator stays private; result only moves on the completing pass
      if (fin) result <= sum;
    end
  end

`ifdef CALC_ALU_OVF_FLAG_EN
  logic ovf_nx;
  always_comb begin
    ovf_nx = 1'b0;
    if (op_r == OP_ADDS)
      ovf_nx = (a_r[WIDTH] == b_r[WIDTH]) && (sum[WIDTH] != a_r[WIDTH]);
    else if (op_r == OP_SUBS)
      ovf_nx = (a_r[WIDTH] != b_r[WIDTH]) && (sum[WIDTH] != a_r[WIDTH]);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)     ovf <= 1'b0;
    else if (clear) ovf <= 1'b0;
    else if (fin)   ovf <= ovf_nx;
`endif

endmodule

// File: tb/tb_calc_alu_sequencer.sv
// Directed + randomized bench for calc_alu_sequencer against an arithmetic reference model.
module tb_calc_alu_sequencer;
  localparam int WIDTH = 7;
  localparam int RW    = 2*WIDTH;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, clear = 1'b0;
  logic [1:0]       op = '0;
  logic [WIDTH:0]   a = '0, b = '0;
  logic             ready, busy, done;
  logic [RW-1:0]    result;
`ifdef CALC_ALU_OVF_FLAG_EN
  logic             ovf;
`endif

  int vectors = 0, miscompares = 0;
  logic [RW-1:0] exp_res = '0;
  logic          exp_ovf = 1'b0;

  always #5 clk = ~clk;

  calc_alu_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .clear(clear),
    .ready(ready), .busy(busy), .done(done),
`ifdef CALC_ALU_OVF_FLAG_EN
    .ovf(ovf),
`endif
    .result(result)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_ovf(input string tag);
`ifdef CALC_ALU_OVF_FLAG_EN
    check(tag, 32'(ovf), 32'(exp_ovf));
`endif
  endtask

  // Reference: plain integer arithmetic on the operand values
  function automatic void model(input logic [1:0] o, input logic [WIDTH:0] x, y,
                                output logic [RW-1:0] r, output logic v);
    int ux, uy, sx, sy, t;
    ux = int'(x[WIDTH-1:0]);
    uy = int'(y[WIDTH-1:0]);
    sx = x[WIDTH] ? int'(x) - (1 << (WIDTH+1)) : int'(x);
    sy = y[WIDTH] ? int'(y) - (1 << (WIDTH+1)) : int'(y);
    v = 1'b0;
    case (o)
      2'b00: r = RW'(ux + uy);
      2'b01: r = RW'(ux * uy);
      2'b10: begin
        r = RW'(int'(x) + (1 << (WIDTH+1)) - int'(y));
        t = sx - sy;
        v = (t > (1 << WIDTH) - 1) || (t < -(1 << WIDTH));
      end
      default: begin
        r = RW'(int'(x) + int'(y));
        t = sx + sy;
        v = (t > (1 << WIDTH) - 1) || (t < -(1 << WIDTH));
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [WIDTH:0] x, y, input bit poke);
    logic [RW-1:0] r;
    logic v;
    int lat;
    model(o, x, y, r, v);
    lat = (o == 2'b01) ? WIDTH + 1 : 2;
    check("ready_pre", 32'(ready), 1);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); a = (WIDTH+1)'($urandom); b = (WIDTH+1)'($urandom);
    for (int k = 1; k <= lat; k++) begin
      if (k == lat) begin exp_res = r; exp_ovf = v; end
      check("busy", 32'(busy), 1);
      check("ready_busy", 32'(ready), 0);
      check("done", 32'(done), 32'(k == lat));
      check("result", 32'(result), 32'(exp_res));
      check_ovf("ovf");
      if (poke && k == 3) begin start = 1'b1; op = 2'b00; end
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("ready_post", 32'(ready), 1);
    check("done_post", 32'(done), 0);
    check("result_hold", 32'(result), 32'(exp_res));
  endtask

  task automatic abort_mul(input bit use_reset, input int at_k);
    op = 2'b01; a = 8'd127; b = 8'd127; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k < at_k; k++) begin
      check("abort_busy", 32'(busy), 1);
      @(posedge clk); #1;
    end
    if (use_reset) begin
      rst_n = 1'b0; #1;
      rst_n = 1'b1 ^ rst_n ^ 1'b1; // stays low for the async checks below
      check("rst_ready", 32'(ready), 1);
      check("rst_busy", 32'(busy), 0);
      check("rst_result", 32'(result), 0);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
    end else begin
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      check("clr_ready", 32'(ready), 1);
      check("clr_busy", 32'(busy), 0);
      check("clr_result", 32'(result), 0);
    end
    exp_res = '0; exp_ovf = 1'b0;
    check_ovf("abort_ovf");
    for (int k = 0; k < WIDTH + 3; k++) begin
      check("abort_nodone", 32'(done), 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [1:0] ro;
    logic [WIDTH:0] ra, rb;
    rst_n = 1'b0;
    #2;
    check("reset_ready", 32'(ready), 1);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_result", 32'(result), 0);
    check_ovf("reset_ovf");
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(2'b00, 8'd127, 8'd127, 1'b0);
    check("addu_const", 32'(result), 32'h00FE);
    run_op(2'b10, 8'h05, 8'h07, 1'b0);
    check("subs_borrow", 32'(result), 32'h00FE);
    run_op(2'b10, 8'h07, 8'h05, 1'b0);
    check("subs_noborrow", 32'(result), 32'h0102);
    run_op(2'b11, 8'h80, 8'hFF, 1'b0);
    check("adds_const", 32'(result), 32'h017F);
`ifdef CALC_ALU_OVF_FLAG_EN
    check("adds_ovf_const", 32'(ovf), 1);
`endif
    run_op(2'b11, 8'h01, 8'h01, 1'b0);
`ifdef CALC_ALU_OVF_FLAG_EN
    check("adds_noovf_const", 32'(ovf), 0);
`endif
    run_op(2'b01, 8'd127, 8'd127, 1'b1);
    check("mul_const", 32'(result), 32'h3F01);
    run_op(2'b01, 8'd0, 8'd99, 1'b0);
    check("mul_zero", 32'(result), 0);

    run_op(2'b01, 8'd127, 8'd127, 1'b0);
    abort_mul(1'b1, 4);
    run_op(2'b01, 8'd127, 8'd127, 1'b0);
    abort_mul(1'b0, 5);

    // start and clear together in IDLE: the request is dropped
    run_op(2'b00, 8'd3, 8'd4, 1'b0);
    start = 1'b1; clear = 1'b1; op = 2'b00; a = 8'd1; b = 8'd1;
    @(posedge clk); #1;
    start = 1'b0; clear = 1'b0;
    exp_res = '0; exp_ovf = 1'b0;
    check("sc_ready", 32'(ready), 1);
    check("sc_busy", 32'(busy), 0);
    check("sc_result", 32'(result), 0);
    @(posedge clk); #1;
    check("sc_nodone", 32'(done), 0);

    for (int n = 0; n < 40; n++) begin
      ro = 2'($urandom_range(0, 3));
      ra = (WIDTH+1)'($urandom);
      rb = (WIDTH+1)'($urandom);
      run_op(ro, ra, rb, n[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
